// File: rtl/mc_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller is the master: it reads IR fields and the Zero flag and drives every mux and enable.
interface mc_controller_if #(
    parameter int SW_W = 4
);
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            zero;
    logic            pc_en;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_write;
    logic [1:0]      reg_dst;
    logic [1:0]      mem_to_reg;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_op;
    logic [1:0]      pc_src;
    logic            retire;
    logic [SW_W-1:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               retire, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               retire, state
    );
endinterface

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle MIPS datapath: one state per datapath step,
// Moore outputs registered from the next state, with a few input-dependent overrides.
module mc_controller #(
    parameter int SW_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    mc_controller_if.master   bus
);
    typedef enum logic [SW_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_BEQ, S_IEXEC, S_IWB, S_JUMP, S_JAL, S_JR
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       retire;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    function automatic logic known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b001;
            6'b100100: return 3'b010;
            6'b100101: return 3'b011;
            6'b101010: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    // Opcode-only dependence here is safe: it is consulted on entry to IEXEC, after IR is loaded.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_en = 1'b1; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.retire = 1'b1; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.retire = 1'b1; end
            S_REXEC:  c.alu_src_a = 1'b1;
            S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 2'b01; c.retire = 1'b1; end
            S_BEQ:    begin c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.retire = 1'b1; end
            S_IEXEC:  begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == OP_SLTI) ? 3'b100 : 3'b000;
            end
            S_IWB:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
            S_JUMP:   begin c.pc_src = 2'b10; c.pc_en = 1'b1; c.retire = 1'b1; end
            S_JAL:    begin
                c.pc_src = 2'b10; c.pc_en = 1'b1; c.reg_write = 1'b1;
                c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.retire = 1'b1;
            end
            S_JR:     begin c.pc_src = 2'b11; c.pc_en = 1'b1; c.retire = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = (bus.funct == FN_JR) ? S_JR : S_REXEC;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH, 6'b000000);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, bus.opcode);
        end
    end

    // IR changes on the FETCH->DECODE edge, so anything depending on the new IR or Zero stays combinational.
    assign bus.pc_en      = ~rst & ((state_q == S_BEQ) ? bus.zero : ctrl_q.pc_en);
    assign bus.alu_op     = (state_q == S_REXEC) ? funct_alu(bus.funct) : ctrl_q.alu_op;
    assign bus.retire     = ~rst & (ctrl_q.retire | ((state_q == S_DECODE) & ~known_op(bus.opcode)));
    assign bus.ir_write   = ~rst & ctrl_q.ir_write;
    assign bus.mem_write  = ~rst & ctrl_q.mem_write;
    assign bus.reg_write  = ~rst & ctrl_q.reg_write;
    assign bus.i_or_d     = ctrl_q.i_or_d;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.pc_src     = ctrl_q.pc_src;
    assign bus.state      = state_q;
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control FSM of the multicycle MIPS datapath; sits directly upstream of the ALU.
- Decodes opcode/funct from the instruction register.
- Drives every datapath mux/enable, including the 3-bit ALU operation code; consumes the ALU Zero flag for beq.
- Moore machine: one state per datapath step, one instruction per 3-5 cycles.

Parameters:
- SW_W, 4, state register width (14 states used).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero flag
- pc_en  out  1  PC load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  2  write register: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = 4, 10 = signext(imm), 11 = signext(imm)<<2
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A
- retire  out  1  one-cycle pulse in the last state of each instruction
- state  out  SW_W  current state, for debug

Behaviour:
- Reset:
  - state = FETCH (0) asynchronously.
  - While rst = 1, pc_en, ir_write, mem_write, reg_write and retire are forced to 0.
  - All other outputs show their FETCH values.
- Outputs decode from state only. Exceptions: alu_op in REXEC uses funct; pc_en in BEQ uses zero. Signals not listed for a state are 0.
- FETCH (0): mem_read, ir_write, i_or_d = 0, src_a = 0, src_b = 01, alu_op = 000, pc_src = 00, pc_en. Next: DECODE.
- DECODE (1): src_a = 0, src_b = 11, alu_op = 000 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 with funct 001000 -> JR
  - 000000 otherwise -> REXEC
  - 000100 -> BEQ
  - 001000 or 001010 -> IEXEC
  - 000010 -> JUMP
  - 000011 -> JAL
  - any other opcode -> FETCH (treated as nop; retire asserted in DECODE)
- MEMADR (2): src_a = 1, src_b = 10, alu_op = 000. Next: MEMRD if opcode = lw, else MEMWR.
- MEMRD (3): mem_read, i_or_d = 1. Next: MEMWB.
- MEMWB (4): reg_write, reg_dst = 00, mem_to_reg = 01, retire. Next: FETCH.
- MEMWR (5): mem_write, i_or_d = 1, retire. Next: FETCH.
- REXEC (6): src_a = 1, src_b = 00. alu_op from funct:
  - 100000 -> 000
  - 100010 -> 001
  - 100100 -> 010
  - 100101 -> 011
  - 101010 -> 100
  - other -> 000
  - Next: RWB.
- RWB (7): reg_write, reg_dst = 01, mem_to_reg = 00, retire. Next: FETCH.
- BEQ (8): src_a = 1, src_b = 00, alu_op = 001, pc_src = 01, pc_en = zero, retire. Next: FETCH.
- IEXEC (9): src_a = 1, src_b = 10, alu_op = 000 for addi, 100 for slti. Next: IWB.
- IWB (10): reg_write, reg_dst = 00, mem_to_reg = 00, retire. Next: FETCH.
- JUMP (11): pc_src = 10, pc_en, retire. Next: FETCH.
- JAL (12): pc_src = 10, pc_en, reg_write, reg_dst = 10, mem_to_reg = 10, retire. Next: FETCH.
  - PC already holds PC+4, so $31 receives the return address in the same cycle.
- JR (13): pc_src = 11, pc_en, retire. Next: FETCH.
- Unused state encodings (14, 15): all enables 0, next state FETCH.
- Latency in cycles: lw 5; R-type, sw, addi/slti 4; beq, j, jal, jr 3; unknown opcode 2.
- Reset mid-instruction: immediate return to FETCH. No partial write occurs after rst rises, because the write enables are gated.
- opcode and funct are sampled combinationally; they must be stable from DECODE until the instruction retires (IR is written only in FETCH).

Test Plan:
- rst pulse during MEMRD -> state = 0 at once; pc_en = ir_write = reg_write = 0 while rst = 1; the first cycle after release shows FETCH outputs with pc_en = 1.
- lw (opcode 100011) -> states 0,1,2,3,4,0; MEMWB shows reg_write = 1, reg_dst = 00, mem_to_reg = 01, retire = 1; 5 cycles total.
- R-type sub (funct 100010) -> REXEC alu_op = 001; RWB reg_dst = 01; slt (funct 101010) gives alu_op = 100; funct 111111 gives alu_op = 000.
- beq with zero = 1 -> BEQ shows pc_en = 1, pc_src = 01; same instruction with zero = 0 -> pc_en = 0; both return to FETCH after 3 cycles.
- jal (000011) -> JAL shows reg_dst = 10, mem_to_reg = 10, pc_src = 10, pc_en = reg_write = 1; jr (000000 with funct 001000) -> state 13, pc_src = 11.
- opcode 111111 -> states 0,1,0 with retire = 1 in DECODE; sw (101011) -> MEMWR mem_write = 1, i_or_d = 1, and reg_write stays 0 throughout.
